// File: rtl/pixel_ser_mc.sv
// Multi-channel one-wire LED serializer: a FIFO dispatcher routes channel-tagged
// words into per-channel 1-entry buffers, each drained by its own bit-timing engine.

package pixel_ser_mc_pkg;
   typedef struct packed {
      logic        eof;
      logic [31:0] pixel;
   } pix_word_t;
endpackage

module pixel_ser_ch
   import pixel_ser_mc_pkg::*;
#(
   parameter int TW = 8,
   parameter int RW = 16
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          fmt32,
   input  logic [TW-1:0] t0h,
   input  logic [TW-1:0] t0l,
   input  logic [TW-1:0] t1h,
   input  logic [TW-1:0] t1l,
   input  logic [RW-1:0] trst,
   input  logic          wr,
   input  pix_word_t     wr_word,
   output logic          ready,
   output logic          ser,
   output logic          busy,
   output logic          underrun
);
   localparam int CW = (RW > TW) ? RW : TW;

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_RST} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   sh_q, sh_d, ld_sh;
   logic [4:0]    bits_q, bits_d;
   pix_word_t     buf_q;
   logic          buf_full_q, consume, take, undr_d, ser_q, undr_q;

   // A programmed length of 0 behaves as 1; counters hold length-1.
   function automatic logic [CW-1:0] ph(input logic [CW-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   assign ld_sh = fmt32 ? buf_q.pixel : {buf_q.pixel[23:0], 8'h00};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bits_d  = bits_q;
      take    = 1'b0;
      undr_d  = 1'b0;
      case (state_q)
         S_IDLE: take = buf_full_q;
         S_HIGH:
            if (cnt_q == '0) begin
               state_d = S_LOW;
               cnt_d   = ph(CW'(sh_q[31] ? t1l : t0l));
            end else cnt_d = cnt_q - 1'b1;
         S_LOW:
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (bits_q != '0) begin
               sh_d    = {sh_q[30:0], 1'b0};
               bits_d  = bits_q - 1'b1;
               state_d = S_HIGH;
               cnt_d   = ph(CW'(sh_q[30] ? t1h : t0h));
            end else if (buf_full_q) take = 1'b1;
            else begin
               state_d = S_IDLE;
               undr_d  = 1'b1;
            end
         S_RST:
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (buf_full_q) take = 1'b1;
            else state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Buffer hand-off shared by idle, end-of-pixel and end-of-reset-code exits.
      if (take) begin
         if (buf_q.eof) begin
            state_d = S_RST;
            cnt_d   = ph(CW'(trst));
         end else begin
            sh_d    = ld_sh;
            bits_d  = fmt32 ? 5'd31 : 5'd23;
            state_d = S_HIGH;
            cnt_d   = ph(CW'(ld_sh[31] ? t1h : t0h));
         end
      end
      consume = take;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         bits_q     <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         ser_q      <= 1'b0;
         undr_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bits_q  <= bits_d;
         ser_q   <= (state_d == S_HIGH);
         undr_q  <= undr_d;
         if (wr) begin
            buf_q      <= wr_word;
            buf_full_q <= 1'b1;
         end else if (consume) buf_full_q <= 1'b0;
      end
   end

   assign ready    = ~buf_full_q | consume;
   assign ser      = ser_q;
   assign busy     = (state_q != S_IDLE) | buf_full_q;
   assign underrun = undr_q;
endmodule

module pixel_ser_mc
   import pixel_ser_mc_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CHW      = 2,
   parameter int TW       = 8,
   parameter int RW       = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                ENABLE,
   input  logic                FORMAT32,
   input  logic                IN_EMPTY,
   output logic                IN_RE,
   input  logic [32+CHW:0]     IN_DATA,
   input  logic [TW-1:0]       ZERO_HIGH_TIMING,
   input  logic [TW-1:0]       ZERO_LOW_TIMING,
   input  logic [TW-1:0]       ONE_HIGH_TIMING,
   input  logic [TW-1:0]       ONE_LOW_TIMING,
   input  logic [RW-1:0]       RESET_CODE_TIMING,
   output logic [CHANNELS-1:0] SER_OUT,
   output logic [CHANNELS-1:0] BUSY,
   output logic [CHANNELS-1:0] UNDERRUN,
   output logic                ERR_CHAN
);
   typedef struct packed {
      logic [CHW-1:0] chan;
      logic           eof;
      logic [31:0]    pixel;
   } hold_t;

   typedef enum logic [1:0] {D_IDLE, D_READ, D_HOLD} dstate_t;

   dstate_t             d_q, d_d;
   hold_t               hold_q;
   pix_word_t           hold_word;
   logic                clr, rd, err_d, err_q, chan_bad;
   logic [CHANNELS-1:0] wr_en, ch_ready;

   assign clr       = RST | ~ENABLE;
   assign chan_bad  = {1'b0, hold_q.chan} >= (CHW+1)'(CHANNELS);
   assign hold_word = {hold_q.eof, hold_q.pixel};

   // Head-of-line blocking: the held word waits for its own channel only.
   always_comb begin
      d_d   = d_q;
      rd    = 1'b0;
      err_d = 1'b0;
      wr_en = '0;
      case (d_q)
         D_IDLE:
            if (!IN_EMPTY) begin
               rd  = 1'b1;
               d_d = D_READ;
            end
         D_READ: d_d = D_HOLD;
         D_HOLD:
            if (chan_bad) begin
               err_d = 1'b1;
               d_d   = D_IDLE;
            end else begin
               for (int i = 0; i < CHANNELS; i++)
                  if (hold_q.chan == CHW'(i) && ch_ready[i]) wr_en[i] = 1'b1;
               if (|wr_en) d_d = D_IDLE;
            end
         default: d_d = D_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (clr) begin
         d_q    <= D_IDLE;
         hold_q <= '0;
         err_q  <= 1'b0;
      end else begin
         d_q   <= d_d;
         err_q <= err_d;
         if (d_q == D_READ) hold_q <= hold_t'(IN_DATA);
      end
   end

   assign IN_RE    = rd & ~clr;
   assign ERR_CHAN = err_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pixel_ser_ch #(.TW(TW), .RW(RW)) u_ch (
         .clk      (CLK),
         .clr      (clr),
         .fmt32    (FORMAT32),
         .t0h      (ZERO_HIGH_TIMING),
         .t0l      (ZERO_LOW_TIMING),
         .t1h      (ONE_HIGH_TIMING),
         .t1l      (ONE_LOW_TIMING),
         .trst     (RESET_CODE_TIMING),
         .wr       (wr_en[g]),
         .wr_word  (hold_word),
         .ready    (ch_ready[g]),
         .ser      (SER_OUT[g]),
         .busy     (BUSY[g]),
         .underrun (UNDERRUN[g])
      );
   end
endmodule

// File: tb/tb_pixel_ser_mc.sv
// Directed bench for pixel_ser_mc: vector table of single pixels plus hand-written multi-cycle sequences.

module tb_pixel_ser_mc;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, fmt32 = 1'b0;
   logic [7:0]  t0h = 8'd3, t0l = 8'd7, t1h = 8'd7, t1l = 8'd3;
   logic [15:0] trst = 16'd20;

   // FIFO models: bench writes fmem/wr_idx, read side pops on IN_RE with 1-cycle latency
   logic [34:0] fmem [0:255];
   logic [34:0] fmem3 [0:255];
   int          wr_idx = 0, rd_idx = 0, wr3 = 0, rd3 = 0, cyc = 0;
   logic [34:0] in_data = '0, in_data3 = '0;
   logic        in_empty, in_empty3, in_re, in_re3, err, err3;
   logic [3:0]  ser, busy, und;
   logic [2:0]  ser3, busy3, und3;

   assign in_empty  = (rd_idx == wr_idx);
   assign in_empty3 = (rd3 == wr3);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (in_re && rd_idx != wr_idx) begin
      in_data <= fmem[rd_idx];
      rd_idx  <= rd_idx + 1;
   end
   always @(posedge clk) if (in_re3 && rd3 != wr3) begin
      in_data3 <= fmem3[rd3];
      rd3      <= rd3 + 1;
   end

   pixel_ser_mc #(.CHANNELS(4), .CHW(2), .TW(8), .RW(16)) u_dut (
      .CLK(clk), .RST(rst), .ENABLE(enable), .FORMAT32(fmt32), .IN_EMPTY(in_empty),
      .IN_RE(in_re), .IN_DATA(in_data), .ZERO_HIGH_TIMING(t0h), .ZERO_LOW_TIMING(t0l),
      .ONE_HIGH_TIMING(t1h), .ONE_LOW_TIMING(t1l), .RESET_CODE_TIMING(trst),
      .SER_OUT(ser), .BUSY(busy), .UNDERRUN(und), .ERR_CHAN(err));

   pixel_ser_mc #(.CHANNELS(3), .CHW(2), .TW(8), .RW(16)) u_dut3 (
      .CLK(clk), .RST(rst), .ENABLE(enable), .FORMAT32(fmt32), .IN_EMPTY(in_empty3),
      .IN_RE(in_re3), .IN_DATA(in_data3), .ZERO_HIGH_TIMING(t0h), .ZERO_LOW_TIMING(t0l),
      .ONE_HIGH_TIMING(t1h), .ONE_LOW_TIMING(t1l), .RESET_CODE_TIMING(trst),
      .SER_OUT(ser3), .BUSY(busy3), .UNDERRUN(und3), .ERR_CHAN(err3));

   int n_run = 0, n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int ch, input bit eof, input logic [31:0] pix);
      logic [1:0] c2;
      c2 = 2'(ch);
      fmem[wr_idx] = {c2, eof, pix};
      wr_idx = wr_idx + 1;
   endtask

   task automatic push3(input int ch, input bit eof, input logic [31:0] pix);
      logic [1:0] c2;
      c2 = 2'(ch);
      fmem3[wr3] = {c2, eof, pix};
      wr3 = wr3 + 1;
   endtask

   // Per-channel observation window: from first high until that channel's UNDERRUN
   int ob_st[4], ob_tot[4], ob_hi[4], ob_first[4], ob_maxlo[4], ob_busylo[4];
   int ob_re, ob_other, ob_err;

   task automatic observe(input logic [3:0] mask, input int bound);
      logic [3:0] done;
      bit         lo_seen[4];
      int         lo[4];
      for (int k = 0; k < 4; k++) begin
         ob_st[k] = -1; ob_tot[k] = 0; ob_hi[k] = 0; ob_first[k] = 0;
         ob_maxlo[k] = 0; ob_busylo[k] = 0; lo[k] = 0; lo_seen[k] = 1'b0;
      end
      done = '0; ob_other = 0; ob_err = 0; ob_re = -1;
      #1;
      if (in_re) ob_re = cyc;
      for (int n = 0; n < bound && done != mask; n++) begin
         @(negedge clk);
         if (in_re && ob_re < 0) ob_re = cyc;
         if (err) ob_err++;
         if ((ser & ~mask) != '0) ob_other = 1;
         for (int k = 0; k < 4; k++) if (mask[k] && !done[k]) begin
            if (und[k]) done[k] = 1'b1;
            else if (ob_st[k] >= 0 || ser[k]) begin
               if (ob_st[k] < 0) ob_st[k] = cyc;
               ob_tot[k]++;
               if (!busy[k]) ob_busylo[k]++;
               if (ser[k]) begin
                  ob_hi[k]++;
                  if (!lo_seen[k]) ob_first[k]++;
                  lo[k] = 0;
               end else begin
                  lo_seen[k] = 1'b1;
                  lo[k]++;
                  if (lo[k] > ob_maxlo[k]) ob_maxlo[k] = lo[k];
               end
            end
         end
      end
      chk("underrun_reached", int'(done), int'(mask));
   endtask

   task automatic wait_high(input int bound);
      int n = 0;
      while (!ser[0] && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ser0_high", int'(ser[0]), 1);
   endtask

   typedef struct {
      int          ch;
      bit          f32;
      logic [31:0] pix;
      logic [7:0]  zh, zl, oh, ol;
      int          e_tot, e_hi, e_first;
   } vec_t;

   vec_t tbl[6];
   int   re_cnt, cnt_a, cnt_b, st, tot;
   bit   fin;

   initial begin
      tbl[0] = '{0, 1'b0, 32'h0080_0000, 8'd3, 8'd7, 8'd7, 8'd3, 240, 76, 7};
      tbl[1] = '{1, 1'b0, 32'h0000_0001, 8'd3, 8'd7, 8'd7, 8'd3, 240, 76, 3};
      tbl[2] = '{3, 1'b1, 32'hF000_0000, 8'd2, 8'd5, 8'd6, 8'd1, 224, 80, 6};
      tbl[3] = '{2, 1'b0, 32'h0012_3456, 8'd0, 8'd0, 8'd0, 8'd0, 48, 24, 1};
      tbl[4] = '{0, 1'b0, 32'hFF00_0000, 8'd3, 8'd7, 8'd7, 8'd3, 240, 72, 3};
      tbl[5] = '{1, 1'b1, 32'hFFFF_FFFF, 8'd1, 8'd1, 8'd4, 8'd4, 256, 128, 4};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ser", int'(ser), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_und", int'(und), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ser3", int'(ser3), 0);
      rst = 1'b0; enable = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         t0h = tbl[i].zh; t0l = tbl[i].zl; t1h = tbl[i].oh; t1l = tbl[i].ol;
         fmt32 = tbl[i].f32;
         push(tbl[i].ch, 1'b0, tbl[i].pix);
         observe(4'(1 << tbl[i].ch), 600);
         chk($sformatf("v%0d_latency", i), ob_st[tbl[i].ch] - ob_re, 4);
         chk($sformatf("v%0d_total", i), ob_tot[tbl[i].ch], tbl[i].e_tot);
         chk($sformatf("v%0d_high", i), ob_hi[tbl[i].ch], tbl[i].e_hi);
         chk($sformatf("v%0d_first_high", i), ob_first[tbl[i].ch], tbl[i].e_first);
         chk($sformatf("v%0d_other_quiet", i), ob_other + ob_err, 0);
         @(negedge clk);
         chk($sformatf("v%0d_und_single", i), int'(und), 0);
         chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
      end

      // back-to-back on ch2
      t0h = 8'd3; t0l = 8'd7; t1h = 8'd7; t1l = 8'd3; fmt32 = 1'b0;
      push(2, 1'b0, 32'h00FF_FFFF);
      push(2, 1'b0, 32'h0000_0000);
      observe(4'b0100, 1200);
      chk("b2b_total", ob_tot[2], 480);
      chk("b2b_high", ob_hi[2], 240);
      chk("b2b_busy_gap", ob_busylo[2], 0);
      chk("b2b_latency", ob_st[2] - ob_re, 4);

      // concurrent ch1 / ch3
      push(1, 1'b0, 32'h00AA_AAAA);
      push(3, 1'b0, 32'h0055_5555);
      observe(4'b1010, 800);
      chk("conc_offset", ob_st[3] - ob_st[1], 3);
      chk("conc_total1", ob_tot[1], 240);
      chk("conc_total3", ob_tot[3], 240);
      chk("conc_high1", ob_hi[1], 120);
      chk("conc_high3", ob_hi[3], 120);
      chk("conc_ch0_ch2_quiet", ob_other, 0);

      // EOF reset code between two 32-bit pixels
      fmt32 = 1'b1; trst = 16'd20;
      push(0, 1'b0, 32'h0102_0304);
      push(0, 1'b1, 32'h0000_0000);
      push(0, 1'b0, 32'h0102_0304);
      observe(4'b0001, 1500);
      chk("eof_total", ob_tot[0], 660);
      chk("eof_high", ob_hi[0], 232);
      chk("eof_max_low", ob_maxlo[0], 27);

      // invalid channel on the 3-channel instance
      fmt32 = 1'b0;
      push3(3, 1'b0, 32'h00FF_FFFF);
      cnt_a = 0; cnt_b = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (err3) cnt_a++;
         if (ser3 != '0 || busy3 != '0) cnt_b++;
      end
      chk("bad_chan_err_pulses", cnt_a, 1);
      chk("bad_chan_activity", cnt_b, 0);
      push3(2, 1'b0, 32'h0080_0000);
      st = -1; tot = 0; fin = 1'b0;
      for (int n = 0; n < 400 && !fin; n++) begin
         @(negedge clk);
         if (und3[2]) fin = 1'b1;
         else if (st >= 0 || ser3[2]) begin
            st = cyc;
            tot++;
         end
      end
      chk("bad_chan_next_total", tot, 240);

      // ENABLE drop mid-pixel; w4 stays in the FIFO behind the blocked hold
      push(0, 1'b0, 32'h00FF_FFFF); push(0, 1'b0, 32'h00FF_FFFF);
      push(0, 1'b0, 32'h00FF_FFFF); push(0, 1'b0, 32'h0080_0000);
      repeat (40) @(negedge clk);
      wait_high(20);
      enable = 1'b0;
      @(negedge clk);
      chk("dis_ser", int'(ser), 0);
      chk("dis_busy", int'(busy), 0);
      re_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (in_re) re_cnt++;
      end
      chk("dis_no_read", re_cnt, 0);
      enable = 1'b1;
      observe(4'b0001, 600);
      chk("dis_resume_latency", ob_st[0] - ob_re, 4);
      chk("dis_resume_total", ob_tot[0], 240);
      chk("dis_resume_high", ob_hi[0], 76);

      // RST mid-pixel
      push(0, 1'b0, 32'h00FF_FFFF); push(0, 1'b0, 32'h00FF_FFFF);
      push(0, 1'b0, 32'h00FF_FFFF); push(0, 1'b0, 32'h0080_0000);
      repeat (40) @(negedge clk);
      wait_high(20);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ser", int'(ser), 0);
      chk("rst_mid_busy", int'(busy), 0);
      re_cnt = 0;
      repeat (3) begin
         if (in_re) re_cnt++;
         @(negedge clk);
      end
      chk("rst_mid_no_read", re_cnt, 0);
      rst = 1'b0;
      observe(4'b0001, 600);
      chk("rst_resume_total", ob_tot[0], 240);
      chk("rst_resume_high", ob_hi[0], 76);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
